bp_be_hazard_tracker: RTL
=========================

// Module: bp_be_hazard_tracker
// PURPOSE
//  Parametrised issue-stage hazard tracker for the BE checker; generalises the fixed 4-stage detector.
//  Tracks N in-flight results in a dep shift register, each with a per-op forwarding latency.
//  Keeps int/fp late-writeback scoreboards, a fence/mem drain check and a dispatch-stall watchdog.
//  Drives dispatch_v_o to the calculator and reports the blocking cause.
// PARAMETERS
//  stages_p         4   tracked exec stages (EX1..EXn), >=2
//  num_rs_p         3   source operands checked per issuing instruction (rs1..rsN)
//  reg_addr_width_p 5   register address width; scoreboards hold 2**reg_addr_width_p bits each
//  lat_width_p      3   width of per-op result latency field
//  watchdog_p       1024 consecutive blocked cycles before stall_timeout_o
// PORTS
//  clk_i            in  1   clock
//  reset_n_i        in  1   synchronous, active-low reset
//  isd_v_i          in  1   instruction valid at issue
//  isd_rs_addr_i    in  num_rs_p*reg_addr_width_p  source addrs, rs1 in LSBs
//  isd_rs_v_i       in  num_rs_p   source used
//  isd_rs_fp_i      in  num_rs_p   source reads FP RF (else int)
//  isd_rd_addr_i    in  reg_addr_width_p  destination
//  isd_rd_v_i       in  1   instruction writes a RF
//  isd_rd_fp_i      in  1   destination is FP RF
//  isd_lat_i        in  lat_width_p  stages until result forwardable (1 = EX1 bypass)
//  isd_fence_i      in  1   fence at issue
//  isd_mem_i        in  1   mem op at issue
//  struct_busy_i    in  1   external structural stall (freeze|ptw|unit not ready)
//  credits_empty_i  in  1   no outstanding mem credits
//  flush_i          in  1   squash all tracked stages
//  score_v_i/score_fp_i/score_rd_i  in 1/1/reg_addr_width_p  mark late writeback pending
//  clear_v_i/clear_fp_i/clear_rd_i  in 1/1/reg_addr_width_p  late writeback done
//  dispatch_v_o     out 1   issue allowed this cycle
//  haz_cause_o      out 4   {struct, control, scoreboard, pipe-data}, one-hot-or-zero priority
//  stall_timeout_o  out 1   sticky watchdog flag
// BEHAVIOUR
//  - Reset (reset_n_i=0 at posedge): all stage entries invalid, scoreboards 0, watchdog 0,
//    stall_timeout_o=0. While reset_n_i=0: dispatch_v_o=0, haz_cause_o=0 (combinational force).
//  - Dispatch = isd_v_i & dispatch_v_o. Dispatched op enters stage 0 next edge with
//    {v, rd, fp, lat, mem}; entries shift 0->stages_p-1 every cycle, last drops. No dispatch -> bubble.
//  - flush_i: all entries invalid next edge (also squashes the same-cycle dispatch); scoreboards kept.
//  - Pipe-data hazard: any used rs_j with entry s valid, rd_v, same RF, same addr, and s+1 < lat.
//    Int addr 0 never matches. lat 0 treated as 1. lat > stages_p saturates to stages_p.
//  - Scoreboard hazard: used rs_j bit set in its RF's board (RAW), or rd bit set (WAW); int x0 ignored.
//    Set on score_v_i, clear on clear_v_i, next edge; same reg/same RF same cycle -> set wins.
//    Int x0 never set.
//  - Control hazard: isd_fence_i & (~credits_empty_i | any valid entry with mem in stages 0..1).
//  - Struct hazard: struct_busy_i.
//  - dispatch_v_o = ~(any hazard); evaluated combinationally from current regs (0 issue latency).
//  - haz_cause_o: highest-priority active cause only, struct > control > scoreboard > data; 0 if none.
//  - Watchdog: counts cycles with isd_v_i & ~dispatch_v_o; resets to 0 on any dispatch or ~isd_v_i.
//    Saturates at watchdog_p; on reaching it stall_timeout_o=1 and stays 1 until reset.
// CONFIGURATION
//  BP_BE_HAZARD_PERF_EN defined: adds out ports perf_stall_o[4*32-1:0]: four 32-bit
//    saturating counters, one per cause, +1 each cycle that cause is reported on haz_cause_o.
//    Reset to 0.
//  Undefined: no ports, no counters; all other behaviour identical.
// TESTING
//  - Reset: hold reset_n_i=0 3 cycles, isd_v_i=1 -> dispatch_v_o=0; release, no deps -> dispatch_v_o=1.
//  - Latency: dispatch rd=x5 lat=3, next cycle issue rs1=x5 -> blocked 2 cycles (s=0,1), dispatch 3rd.
//    Same with lat=1 -> no stall.
//  - x0/RF: in-flight int rd=x0 lat=4 and fp rd=f7; issue int rs1=x0, rs2=x7 -> no stall.
//  - Scoreboard: score int x9; issue rs2=x9 stalls, cause=0010. Same-cycle score+clear x9 -> stays set.
//    clear alone -> dispatch next cycle.
//  - Fence: credits_empty_i=0, isd_fence_i=1 -> cause=0100. Flush with mem in stage 0 + credits_empty_i=1
//    -> dispatch next cycle.
//  - Watchdog (watchdog_p=8): struct_busy_i=1 for 8 cycles -> stall_timeout_o=1 on cycle 8, sticky after
//    busy drops. Perf build: struct counter=8.

Source files
------------

// File: rtl/bp_be_hazard_tracker.sv
// bp_be_hazard_tracker: issue-stage hazard tracker for the BE checker.
// Tracks in-flight results in a shift register with per-op forwarding latency,
// keeps int/fp late-writeback scoreboards, checks fence/mem drain, and runs a
// dispatch-stall watchdog. haz_cause_o = {struct, control, scoreboard, data}.
// Optional build macro BP_BE_HAZARD_PERF_EN adds perf_stall_o (4 x 32-bit
// saturating per-cause stall counters, cause i in bits [32*i +: 32]).
module bp_be_hazard_tracker #(
  parameter int unsigned stages_p         = 4,
  parameter int unsigned num_rs_p         = 3,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned lat_width_p      = 3,
  parameter int unsigned watchdog_p       = 1024
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 isd_v_i,
  input  logic [num_rs_p*reg_addr_width_p-1:0] isd_rs_addr_i,
  input  logic [num_rs_p-1:0]                  isd_rs_v_i,
  input  logic [num_rs_p-1:0]                  isd_rs_fp_i,
  input  logic [reg_addr_width_p-1:0]          isd_rd_addr_i,
  input  logic                                 isd_rd_v_i,
  input  logic                                 isd_rd_fp_i,
  input  logic [lat_width_p-1:0]               isd_lat_i,
  input  logic                                 isd_fence_i,
  input  logic                                 isd_mem_i,
  input  logic                                 struct_busy_i,
  input  logic                                 credits_empty_i,
  input  logic                                 flush_i,
  input  logic                                 score_v_i,
  input  logic                                 score_fp_i,
  input  logic [reg_addr_width_p-1:0]          score_rd_i,
  input  logic                                 clear_v_i,
  input  logic                                 clear_fp_i,
  input  logic [reg_addr_width_p-1:0]          clear_rd_i,
  output logic                                 dispatch_v_o,
  output logic [3:0]                           haz_cause_o,
  output logic                                 stall_timeout_o
`ifdef BP_BE_HAZARD_PERF_EN
  ,
  output logic [4*32-1:0]                      perf_stall_o
`endif
);

  localparam int unsigned regs_lp     = 2 ** reg_addr_width_p;
  localparam int unsigned lat_st_w_lp = $clog2(stages_p + 1);
  localparam int unsigned wd_w_lp     = $clog2(watchdog_p + 1);

  // In-flight result entries, index 0 = EX1
  logic [stages_p-1:0]         r_v;
  logic [stages_p-1:0]         r_rd_v;
  logic [stages_p-1:0]         r_fp;
  logic [stages_p-1:0]         r_mem;
  logic [reg_addr_width_p-1:0] r_rd  [stages_p];
  logic [lat_st_w_lp-1:0]      r_lat [stages_p];

  logic [regs_lp-1:0]          r_int_sb;
  logic [regs_lp-1:0]          r_fp_sb;
  logic [wd_w_lp-1:0]          r_wd_cnt;
  logic                        r_timeout;

  logic [reg_addr_width_p-1:0] w_rs [num_rs_p];
  logic [lat_st_w_lp-1:0]      w_lat_sat;
  logic                        w_data_haz;
  logic                        w_sb_haz;
  logic                        w_ctrl_haz;
  logic                        w_struct_haz;
  logic                        w_dispatch;
  logic [regs_lp-1:0]          w_int_set;
  logic [regs_lp-1:0]          w_int_clr;
  logic [regs_lp-1:0]          w_fp_set;
  logic [regs_lp-1:0]          w_fp_clr;
  logic                        w_blocked;
  logic [wd_w_lp-1:0]          w_wd_next;

  // Split the packed source-address bus, rs1 in the LSBs
  always_comb begin
    for (int unsigned j = 0; j < num_rs_p; j++) begin
      w_rs[j] = isd_rs_addr_i[j*reg_addr_width_p +: reg_addr_width_p];
    end
  end

  // Normalise issue latency: 0 behaves as 1, anything past the last stage saturates
  always_comb begin
    w_lat_sat = lat_st_w_lp'(stages_p);
    if (isd_lat_i == '0) begin
      w_lat_sat = lat_st_w_lp'(1);
    end else if (32'(isd_lat_i) <= stages_p) begin
      w_lat_sat = lat_st_w_lp'(isd_lat_i);
    end
  end

  // Pipe-data hazard: a used source matches an entry whose result is not yet forwardable
  always_comb begin
    w_data_haz = 1'b0;
    for (int unsigned j = 0; j < num_rs_p; j++) begin
      for (int unsigned s = 0; s < stages_p; s++) begin
        if (isd_rs_v_i[j] && r_v[s] && r_rd_v[s]
            && (r_fp[s] == isd_rs_fp_i[j]) && (r_rd[s] == w_rs[j])
            && (isd_rs_fp_i[j] || (w_rs[j] != '0))
            && ((s + 1) < 32'(r_lat[s]))) begin
          w_data_haz = 1'b1;
        end
      end
    end
  end

  // Scoreboard hazard: RAW on any used source, WAW on the destination; int x0 exempt
  always_comb begin
    w_sb_haz = 1'b0;
    for (int unsigned j = 0; j < num_rs_p; j++) begin
      if (isd_rs_v_i[j]) begin
        if (isd_rs_fp_i[j]) begin
          if (r_fp_sb[w_rs[j]]) w_sb_haz = 1'b1;
        end else if ((w_rs[j] != '0) && r_int_sb[w_rs[j]]) begin
          w_sb_haz = 1'b1;
        end
      end
    end
    if (isd_rd_v_i) begin
      if (isd_rd_fp_i) begin
        if (r_fp_sb[isd_rd_addr_i]) w_sb_haz = 1'b1;
      end else if ((isd_rd_addr_i != '0) && r_int_sb[isd_rd_addr_i]) begin
        w_sb_haz = 1'b1;
      end
    end
  end

  // Control and structural hazards, priority-encoded cause and dispatch decision
  always_comb begin
    w_ctrl_haz   = isd_fence_i & (~credits_empty_i
                   | (r_v[0] & r_mem[0]) | (r_v[1] & r_mem[1]));
    w_struct_haz = struct_busy_i;
    haz_cause_o  = '0;
    if (reset_n_i) begin
      if (w_struct_haz)    haz_cause_o = 4'b1000;
      else if (w_ctrl_haz) haz_cause_o = 4'b0100;
      else if (w_sb_haz)   haz_cause_o = 4'b0010;
      else if (w_data_haz) haz_cause_o = 4'b0001;
    end
    dispatch_v_o = reset_n_i & ~(w_struct_haz | w_ctrl_haz | w_sb_haz | w_data_haz);
    w_dispatch   = isd_v_i & dispatch_v_o;
  end

  // Dispatched op enters EX1, everything shifts one stage; flush squashes all including the new op
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_v    <= '0;
      r_rd_v <= '0;
      r_fp   <= '0;
      r_mem  <= '0;
      for (int unsigned s = 0; s < stages_p; s++) begin
        r_rd[s]  <= '0;
        r_lat[s] <= '0;
      end
    end else begin
      r_v[0]    <= w_dispatch & ~flush_i;
      r_rd_v[0] <= isd_rd_v_i;
      r_fp[0]   <= isd_rd_fp_i;
      r_mem[0]  <= isd_mem_i;
      r_rd[0]   <= isd_rd_addr_i;
      r_lat[0]  <= w_lat_sat;
      for (int unsigned s = 1; s < stages_p; s++) begin
        r_v[s]    <= r_v[s-1] & ~flush_i;
        r_rd_v[s] <= r_rd_v[s-1];
        r_fp[s]   <= r_fp[s-1];
        r_mem[s]  <= r_mem[s-1];
        r_rd[s]   <= r_rd[s-1];
        r_lat[s]  <= r_lat[s-1];
      end
    end
  end

  // One-hot set/clear masks for the late-writeback scoreboards; int x0 is never marked
  always_comb begin
    w_int_set = '0;
    w_int_clr = '0;
    w_fp_set  = '0;
    w_fp_clr  = '0;
    if (score_v_i) begin
      if (score_fp_i)             w_fp_set[score_rd_i]  = 1'b1;
      else if (score_rd_i != '0)  w_int_set[score_rd_i] = 1'b1;
    end
    if (clear_v_i) begin
      if (clear_fp_i) w_fp_clr[clear_rd_i]  = 1'b1;
      else            w_int_clr[clear_rd_i] = 1'b1;
    end
  end

  // Scoreboard update: clear applied first so a same-cycle set on the same reg wins
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_int_sb <= '0;
      r_fp_sb  <= '0;
    end else begin
      r_int_sb <= (r_int_sb & ~w_int_clr) | w_int_set;
      r_fp_sb  <= (r_fp_sb  & ~w_fp_clr)  | w_fp_set;
    end
  end

  // Next watchdog count: saturating while blocked, otherwise back to zero
  always_comb begin
    w_blocked = isd_v_i & ~dispatch_v_o;
    w_wd_next = '0;
    if (w_blocked) begin
      if (r_wd_cnt == wd_w_lp'(watchdog_p)) w_wd_next = r_wd_cnt;
      else                                  w_wd_next = r_wd_cnt + 1'b1;
    end
  end

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd_cnt  <= w_wd_next;
      r_timeout <= r_timeout | (w_wd_next == wd_w_lp'(watchdog_p));
    end
  end

  assign stall_timeout_o = r_timeout;

`ifdef BP_BE_HAZARD_PERF_EN
  logic [31:0] r_perf [4];

  // Per-cause saturating stall counters, bumped when that cause is the reported one
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < 4; i++) r_perf[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (haz_cause_o[i] && (r_perf[i] != '1)) r_perf[i] <= r_perf[i] + 1'b1;
      end
    end
  end

  // Pack counters onto the output bus
  always_comb begin
    perf_stall_o = '0;
    for (int unsigned i = 0; i < 4; i++) perf_stall_o[i*32 +: 32] = r_perf[i];
  end
`endif

endmodule
